// File: rtl/mem_stage.sv
// mem_stage: EX->MEM pipeline register, data-memory handshake,
// load alignment/extension and the WB / EX-forwarding buses.
module mem_stage #(
   parameter int EX2MEM_WD = 235,
   parameter int MEM2WB_WD = 166,
   parameter int MEM2EX_WD = 70
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [5:0]           stall,
   input  logic [EX2MEM_WD-1:0] ex2mem_bus,
   output logic [MEM2WB_WD-1:0] mem2wb_bus,
   output logic [MEM2EX_WD-1:0] mem2ex_fwd,
   output logic                 stallreq_mem,
   output logic                 dmem_req,
   input  logic                 dmem_gnt,
   output logic                 dmem_we,
   output logic [63:0]          dmem_addr,
   output logic [7:0]           dmem_wstrb,
   output logic [63:0]          dmem_wdata,
   input  logic                 dmem_rvalid,
   input  logic [63:0]          dmem_rdata
);

   typedef struct packed {
      logic        mem_re;
      logic        mem_we;
      logic [1:0]  mem_size;
      logic        mem_unsigned;
      logic        rf_we;
      logic [4:0]  rf_waddr;
      logic [63:0] ex_result;
      logic [63:0] store_data;
      logic [63:0] pc;
      logic [31:0] inst;
   } ex2mem_t;

   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

   ex2mem_t     bus_r;
   state_t      state, state_nx;
   logic [63:0] load_buf;
   logic        mem_op;
   logic [2:0]  off;
   logic [7:0]  strb;
   logic [63:0] wd;
   logic [7:0]  ld_b;
   logic [15:0] ld_h;
   logic [31:0] ld_w;
   logic [63:0] ld_ext;
   logic [63:0] rf_wdata;
   logic        unused_stall;

   assign unused_stall = ^{stall[5], stall[2:0]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus_r <= '0;
      end else if (!stall[3]) begin
         bus_r <= ex2mem_bus;
      end else if (!stall[4]) begin
         bus_r <= '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         load_buf <= '0;
      end else begin
         state <= state_nx;
         if (state == WAIT && dmem_rvalid) begin
            load_buf <= dmem_rdata;
         end
      end
   end

   assign mem_op = bus_r.mem_re | bus_r.mem_we;

   always_comb begin
      state_nx = state;
      dmem_req = 1'b0;
      unique case (state)
         IDLE: begin
            dmem_req = mem_op;
            if (mem_op && dmem_gnt) state_nx = WAIT;
         end
         WAIT: begin
            if (dmem_rvalid) state_nx = DONE;
         end
         DONE: begin
            if (!stall[3]) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   assign stallreq_mem = mem_op & (state != DONE);

   assign off = bus_r.ex_result[2:0];

   always_comb begin
      strb = 8'hFF;
      wd   = bus_r.store_data;
      unique case (bus_r.mem_size)
         2'd0: begin
            strb = 8'h01 << off;
            wd   = {8{bus_r.store_data[7:0]}};
         end
         2'd1: begin
            strb = 8'h03 << {off[2:1], 1'b0};
            wd   = {4{bus_r.store_data[15:0]}};
         end
         2'd2: begin
            strb = 8'h0F << {off[2], 2'b00};
            wd   = {2{bus_r.store_data[31:0]}};
         end
         default: ;
      endcase
   end

   assign dmem_we    = bus_r.mem_we;
   assign dmem_addr  = {bus_r.ex_result[63:3], 3'b000};
   assign dmem_wstrb = bus_r.mem_we ? strb : 8'h00;
   assign dmem_wdata = wd;

   assign ld_b = 8'(load_buf >> {off, 3'b000});
   assign ld_h = 16'(load_buf >> {off[2:1], 4'b0000});
   assign ld_w = 32'(load_buf >> {off[2], 5'b00000});

   always_comb begin
      ld_ext = load_buf;
      unique case (bus_r.mem_size)
         2'd0: ld_ext = bus_r.mem_unsigned ? {56'b0, ld_b}
                                           : {{56{ld_b[7]}}, ld_b};
         2'd1: ld_ext = bus_r.mem_unsigned ? {48'b0, ld_h}
                                           : {{48{ld_h[15]}}, ld_h};
         2'd2: ld_ext = bus_r.mem_unsigned ? {32'b0, ld_w}
                                           : {{32{ld_w[31]}}, ld_w};
         default: ;
      endcase
   end

   assign rf_wdata = bus_r.mem_re ? ld_ext : bus_r.ex_result;

   assign mem2wb_bus = {bus_r.rf_we, bus_r.rf_waddr, rf_wdata,
                        bus_r.pc, bus_r.inst};
   assign mem2ex_fwd = mem2wb_bus[MEM2WB_WD-1 -: MEM2EX_WD];

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: scoreboard of expected writebacks,
// checked with immediate assertions as each op leaves MEM.
module tb_mem_stage;

   typedef struct packed {
      logic        rf_we;
      logic [4:0]  wa;
      logic [63:0] wd;
      logic [63:0] pc;
      logic [31:0] inst;
   } wb_t;

   logic         clk;
   logic         rst_n;
   logic [5:0]   stall;
   logic [234:0] ex2mem_bus;
   logic [165:0] mem2wb_bus;
   logic [69:0]  mem2ex_fwd;
   logic         stallreq_mem;
   logic         dmem_req;
   logic         dmem_gnt;
   logic         dmem_we;
   logic [63:0]  dmem_addr;
   logic [7:0]   dmem_wstrb;
   logic [63:0]  dmem_wdata;
   logic         dmem_rvalid;
   logic [63:0]  dmem_rdata;
   logic         ext3, ext4;

   int checks   = 0;
   int failures = 0;
   wb_t sb[$];

   mem_stage dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .stall        (stall),
      .ex2mem_bus   (ex2mem_bus),
      .mem2wb_bus   (mem2wb_bus),
      .mem2ex_fwd   (mem2ex_fwd),
      .stallreq_mem (stallreq_mem),
      .dmem_req     (dmem_req),
      .dmem_gnt     (dmem_gnt),
      .dmem_we      (dmem_we),
      .dmem_addr    (dmem_addr),
      .dmem_wstrb   (dmem_wstrb),
      .dmem_wdata   (dmem_wdata),
      .dmem_rvalid  (dmem_rvalid),
      .dmem_rdata   (dmem_rdata)
   );

   // Pipeline controller model: a MEM stall freezes stages 0..4.
   assign stall = {1'b0, ext4 | stallreq_mem, ext3 | stallreq_mem,
                   {3{stallreq_mem}}};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [255:0] obs,
                      input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [234:0] mk(
      input logic re, input logic we, input logic [1:0] sz,
      input logic uns, input logic rfwe, input logic [4:0] wa,
      input logic [63:0] exr, input logic [63:0] sd,
      input logic [63:0] pc, input logic [31:0] inst);
      return {re, we, sz, uns, rfwe, wa, exr, sd, pc, inst};
   endfunction

   function automatic wb_t mkwb(input logic rfwe, input logic [4:0] wa,
                                input logic [63:0] wd,
                                input logic [63:0] pc,
                                input logic [31:0] inst);
      wb_t e;
      e.rf_we = rfwe;
      e.wa    = wa;
      e.wd    = wd;
      e.pc    = pc;
      e.inst  = inst;
      return e;
   endfunction

   task automatic check_wb();
      wb_t e;
      chk("sb_nonempty", 256'(sb.size() != 0), 256'd1);
      if (sb.size() != 0) begin
         e = sb.pop_front();
         chk("mem2wb", 256'(mem2wb_bus), 256'(e));
         chk("mem2ex_fwd", 256'(mem2ex_fwd), 256'(e[165:96]));
      end
   endtask

   task automatic run_alu(input logic [234:0] b);
      @(negedge clk);
      ex2mem_bus = b;
      @(negedge clk);
      ex2mem_bus = '0;
      chk("alu_stallreq", 256'(stallreq_mem), 256'd0);
      chk("alu_req", 256'(dmem_req), 256'd0);
      check_wb();
   endtask

   // Issues one memory op, delays gnt by gdly cycles, returns in DONE.
   task automatic run_mem(input logic [234:0] b, input int gdly,
                          input logic [63:0] rd,
                          input logic [63:0] eaddr,
                          input logic [7:0] estrb,
                          input logic [63:0] ewd);
      int sc;
      sc = 0;
      @(negedge clk);
      ex2mem_bus = b;
      @(negedge clk);
      ex2mem_bus = '0;
      for (int i = 0; i <= gdly; i++) begin
         if (i > 0) @(negedge clk);
         chk("req_hold", 256'(dmem_req), 256'd1);
         chk("addr", 256'(dmem_addr), 256'(eaddr));
         chk("wstrb", 256'(dmem_wstrb), 256'(estrb));
         chk("wdata", 256'(dmem_wdata), 256'(ewd));
         chk("we", 256'(dmem_we), 256'(b[233]));
         if (stallreq_mem) sc++;
         dmem_gnt = (i == gdly);
      end
      @(negedge clk);
      dmem_gnt = 1'b0;
      chk("req_wait", 256'(dmem_req), 256'd0);
      if (stallreq_mem) sc++;
      dmem_rvalid = 1'b1;
      dmem_rdata  = rd;
      @(negedge clk);
      dmem_rvalid = 1'b0;
      dmem_rdata  = {$urandom, $urandom};
      chk("stall_cycles", 256'(sc), 256'(gdly + 2));
      chk("stall_done", 256'(stallreq_mem), 256'd0);
      chk("req_done", 256'(dmem_req), 256'd0);
      check_wb();
   endtask

   wb_t hold_e;

   initial begin
      rst_n       = 1'b0;
      ex2mem_bus  = '0;
      dmem_gnt    = 1'b0;
      dmem_rvalid = 1'b0;
      dmem_rdata  = '0;
      ext3        = 1'b0;
      ext4        = 1'b0;
      #3;
      chk("rst_req", 256'(dmem_req), 256'd0);
      chk("rst_stallreq", 256'(stallreq_mem), 256'd0);
      chk("rst_mem2wb", 256'(mem2wb_bus), 256'd0);
      chk("rst_fwd", 256'(mem2ex_fwd), 256'd0);
      chk("rst_wstrb", 256'(dmem_wstrb), 256'd0);
      chk("rst_addr", 256'(dmem_addr), 256'd0);
      @(negedge clk);
      rst_n = 1'b1;

      sb.push_back(mkwb(1'b1, 5'd5, 64'h1234, 64'h100, 32'h13));
      run_alu(mk(0, 0, 2'd3, 0, 1, 5'd5, 64'h1234, 64'h0,
                 64'h100, 32'h13));

      sb.push_back(mkwb(1'b1, 5'd7, 64'hFFFFFFFF_FFFFFF80,
                        64'h104, 32'h00308383));
      run_mem(mk(1, 0, 2'd0, 0, 1, 5'd7, 64'h1003, 64'h0,
                 64'h104, 32'h00308383),
              0, 64'h00000000_80FF0000, 64'h1000, 8'h00, 64'h0);

      sb.push_back(mkwb(1'b1, 5'd9, 64'h8001, 64'h108, 32'h00655483));
      run_mem(mk(1, 0, 2'd1, 1, 1, 5'd9, 64'h2006, 64'h0,
                 64'h108, 32'h00655483),
              3, 64'h8001_0000_0000_0000, 64'h2000, 8'h00, 64'h0);

      sb.push_back(mkwb(1'b1, 5'd10, 64'hFFFFFFFF_FFFFF234,
                        64'h10C, 32'h00211503));
      run_mem(mk(1, 0, 2'd1, 0, 1, 5'd10, 64'h6002, 64'h0,
                 64'h10C, 32'h00211503),
              1, 64'h00000000_F2340000, 64'h6000, 8'h00, 64'h0);

      sb.push_back(mkwb(1'b1, 5'd11, 64'hFFFFFFFF_80000000,
                        64'h110, 32'h00422583));
      run_mem(mk(1, 0, 2'd2, 0, 1, 5'd11, 64'h6004, 64'h0,
                 64'h110, 32'h00422583),
              0, 64'h80000000_00000000, 64'h6000, 8'h00, 64'h0);

      sb.push_back(mkwb(1'b0, 5'd0, 64'h3004, 64'h114, 32'h00a12223));
      run_mem(mk(0, 1, 2'd2, 0, 0, 5'd0, 64'h3004,
                 64'h12345678_DEADBEEF, 64'h114, 32'h00a12223),
              0, 64'h0, 64'h3000, 8'hF0, 64'hDEADBEEF_DEADBEEF);

      sb.push_back(mkwb(1'b0, 5'd0, 64'h3005, 64'h118, 32'h00a102a3));
      run_mem(mk(0, 1, 2'd0, 0, 0, 5'd0, 64'h3005,
                 64'h11223344_556677AB, 64'h118, 32'h00a102a3),
              2, 64'h0, 64'h3000, 8'h20, {8{8'hAB}});

      hold_e = mkwb(1'b1, 5'd3, 64'h01234567_89ABCDEF,
                    64'h11C, 32'h00003183);
      sb.push_back(hold_e);
      run_mem(mk(1, 0, 2'd3, 0, 1, 5'd3, 64'h4000, 64'h0,
                 64'h11C, 32'h00003183),
              0, 64'h01234567_89ABCDEF, 64'h4000, 8'h00, 64'h0);
      ext3 = 1'b1;
      ext4 = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("hold_req", 256'(dmem_req), 256'd0);
         chk("hold_stallreq", 256'(stallreq_mem), 256'd0);
         chk("hold_mem2wb", 256'(mem2wb_bus), 256'(hold_e));
      end
      ext4 = 1'b0;
      @(negedge clk);
      chk("bubble_mem2wb", 256'(mem2wb_bus), 256'd0);
      chk("bubble_stallreq", 256'(stallreq_mem), 256'd0);
      chk("bubble_req", 256'(dmem_req), 256'd0);
      ext3 = 1'b0;
      @(negedge clk);

      ex2mem_bus = mk(1, 0, 2'd2, 0, 1, 5'd12, 64'h5000, 64'h0,
                      64'h120, 32'h00002603);
      @(negedge clk);
      ex2mem_bus = '0;
      dmem_gnt   = 1'b1;
      @(negedge clk);
      dmem_gnt = 1'b0;
      chk("wait_req", 256'(dmem_req), 256'd0);
      chk("wait_stallreq", 256'(stallreq_mem), 256'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_req", 256'(dmem_req), 256'd0);
      chk("arst_stallreq", 256'(stallreq_mem), 256'd0);
      chk("arst_mem2wb", 256'(mem2wb_bus), 256'd0);
      chk("arst_fwd", 256'(mem2ex_fwd), 256'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      dmem_rvalid = 1'b1;
      dmem_rdata  = 64'hFFFFFFFF_FFFFFFFF;
      @(negedge clk);
      dmem_rvalid = 1'b0;
      chk("stray_stallreq", 256'(stallreq_mem), 256'd0);
      chk("stray_req", 256'(dmem_req), 256'd0);
      chk("stray_mem2wb", 256'(mem2wb_bus), 256'd0);

      sb.push_back(mkwb(1'b1, 5'd4, 64'h5A, 64'h124, 32'h00004203));
      run_mem(mk(1, 0, 2'd0, 1, 1, 5'd4, 64'h7000, 64'h0,
                 64'h124, 32'h00004203),
              0, 64'h00000000_0000005A, 64'h7000, 8'h00, 64'h0);

      sb.push_back(mkwb(1'b1, 5'd6, 64'hCAFE, 64'h128, 32'h00b50333));
      run_alu(mk(0, 0, 2'd0, 0, 1, 5'd6, 64'hCAFE, 64'h0,
                 64'h128, 32'h00b50333));

      chk("sb_drained", 256'(sb.size()), 256'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
